// File: rtl/cdb_arbiter_pkg.sv
// Shared constants and helpers for the result-bus arbiter.
// Parameter defaults live here so every instantiation site agrees on them.
package cdb_arbiter_pkg;

    localparam int CDB_WIDTH_DEF = 32;
    localparam int CDB_NREQS_DEF = 4;

    // Advance a rotating index. The wrap is written out explicitly because
    // N_REQS need not be a power of two.
    function automatic int wrap_inc(input int idx, input int max_idx);
        return (idx >= max_idx) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/onehot_encoder.sv
// Converts a one-hot vector to its bit index.
// An all-zero input encodes to index 0.
module onehot_encoder #(
    parameter int N_INS = 4
) (
    input  logic [N_INS-1:0]         i_onehot,
    output logic [$clog2(N_INS)-1:0] o_idx
);

    localparam int IDX_W = $clog2(N_INS);

    always_comb begin
        o_idx = '0;
        for (int i = 0; i < N_INS; i++) begin
            if (i_onehot[i]) begin
                o_idx = o_idx | IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/onehot_mux.sv
// AND-OR multiplexer driven by a one-hot (or all-zero) select.
// An all-zero select produces an all-zero output.
module onehot_mux #(
    parameter int WIDTH = 32,
    parameter int N_INS = 4
) (
    input  logic [N_INS-1:0]            i_sel,
    input  logic [N_INS-1:0][WIDTH-1:0] i_data,
    output logic [WIDTH-1:0]            o_data
);

    always_comb begin
        o_data = '0;
        for (int i = 0; i < N_INS; i++) begin
            o_data = o_data | (i_data[i] & {WIDTH{i_sel[i]}});
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the shared result bus, followed by a
// single-entry valid/ready output register that retires and reloads without a bubble.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int WIDTH  = CDB_WIDTH_DEF,
    parameter int N_REQS = CDB_NREQS_DEF
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [N_REQS-1:0]                req_valid,
    input  logic [N_REQS-1:0][WIDTH-1:0]     req_data,
    output logic [N_REQS-1:0]                req_ready,
    output logic [N_REQS-1:0]                grant,
    output logic                             out_valid,
    output logic [WIDTH-1:0]                 out_data,
    output logic [$clog2(N_REQS)-1:0]        out_src,
    input  logic                             out_ready
);

    localparam int PTR_W   = $clog2(N_REQS);
    localparam int MAX_IDX = N_REQS - 1;

    logic [PTR_W-1:0]  r_ptr;
    logic              r_out_valid;
    logic [WIDTH-1:0]  r_out_data;
    logic [PTR_W-1:0]  r_out_src;

    logic [N_REQS-1:0] w_grant;
    logic              w_found;
    logic [PTR_W:0]    w_scan;
    logic              w_load;
    logic              w_xfer;
    logic [WIDTH-1:0]  w_sel_data;
    logic [PTR_W-1:0]  w_grant_idx;

    // Scan from r_ptr upward, folding back below N_REQS; the extra bit in
    // w_scan keeps the sum from overflowing before the fold.
    always_comb begin
        w_grant = '0;
        w_found = 1'b0;
        w_scan  = '0;
        for (int k = 0; k < N_REQS; k++) begin
            w_scan = {1'b0, r_ptr} + (PTR_W+1)'(k);
            if (w_scan > (PTR_W+1)'(MAX_IDX)) begin
                w_scan = w_scan - (PTR_W+1)'(N_REQS);
            end
            if (!w_found && req_valid[w_scan[PTR_W-1:0]]) begin
                w_grant[w_scan[PTR_W-1:0]] = 1'b1;
                w_found = 1'b1;
            end
        end
    end

    assign w_load    = ~r_out_valid | out_ready;
    assign req_ready = w_grant & {N_REQS{w_load & ~rst}};
    assign w_xfer    = |(req_valid & req_ready);
    assign grant     = w_grant;

    onehot_mux #(
        .WIDTH (WIDTH),
        .N_INS (N_REQS)
    ) u_mux (
        .i_sel  (w_grant),
        .i_data (req_data),
        .o_data (w_sel_data)
    );

    onehot_encoder #(
        .N_INS (N_REQS)
    ) u_enc (
        .i_onehot (w_grant),
        .o_idx    (w_grant_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_src   <= '0;
        end else if (w_load) begin
            r_out_valid <= w_xfer;
            if (w_xfer) begin
                r_out_data <= w_sel_data;
                r_out_src  <= w_grant_idx;
                r_ptr      <= PTR_W'(wrap_inc(int'(w_grant_idx), MAX_IDX));
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_src   = r_out_src;

    a_grant_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(grant));
    a_ready_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(req_ready));
    a_stall_stable:  assert property (@(posedge clk) disable iff (rst)
        (r_out_valid && !out_ready) |=> ($stable(r_out_data) && $stable(r_out_src)));

endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomised scoreboard bench for cdb_arbiter (N_REQS=4), plus a short
// directed run of a 3-requester instance for the non-power-of-two wrap.
module tb_cdb_arbiter;

    localparam int W = 32;
    localparam int N = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst       = 1'b1;
    logic [N-1:0]        req_valid = '0;
    logic [N-1:0][W-1:0] req_data  = '0;
    logic [N-1:0]        req_ready;
    logic [N-1:0]        grant;
    logic                out_valid;
    logic [W-1:0]        out_data;
    logic [1:0]          out_src;
    logic                out_ready = 1'b0;

    logic [2:0]          rv3   = '0;
    logic [2:0][W-1:0]   rd3   = '0;
    logic [2:0]          rr3;
    logic [2:0]          g3;
    logic                ov3;
    logic [W-1:0]        od3;
    logic [1:0]          os3;
    logic                ordy3 = 1'b1;

    cdb_arbiter #(.WIDTH(W), .N_REQS(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .grant     (grant),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    cdb_arbiter #(.WIDTH(W), .N_REQS(3)) dut3 (
        .clk       (clk),
        .rst       (rst),
        .req_valid (rv3),
        .req_data  (rd3),
        .req_ready (rr3),
        .grant     (g3),
        .out_valid (ov3),
        .out_data  (od3),
        .out_src   (os3),
        .out_ready (ordy3)
    );

    typedef struct {
        logic [W-1:0] d;
        int           s;
    } item_t;

    item_t exp_q[$];
    int    checks  = 0;
    int    errors  = 0;
    bit    m_valid = 1'b0;
    int    m_ptr   = 0;

    function automatic int scan(input logic [N-1:0] v, input int p);
        int idx;
        for (int k = 0; k < N; k++) begin
            idx = (p + k) % N;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // One clock of stimulus; the reference model decides what the DUT must
    // show this cycle and what it must later present on the output.
    task automatic cycle(input bit r, input logic [N-1:0] v, input bit rdy);
        int           w;
        logic [N-1:0] eg;
        @(posedge clk);
        #1;
        rst       = r;
        req_valid = v;
        out_ready = rdy;
        for (int k = 0; k < N; k++) req_data[k] = $urandom;
        #1;
        chk("out_valid", {63'd0, out_valid}, {63'd0, m_valid});
        w  = scan(v, m_ptr);
        eg = '0;
        if (w >= 0) eg[w] = 1'b1;
        chk("grant", 64'(grant), 64'(eg));
        if (r) begin
            chk("req_ready_rst", 64'(req_ready), 64'd0);
            exp_q.delete();
            m_valid = 1'b0;
            m_ptr   = 0;
        end else if (!m_valid || rdy) begin
            chk("req_ready", 64'(req_ready), 64'(eg));
            if (w >= 0) begin
                exp_q.push_back('{req_data[w], w});
                m_valid = 1'b1;
                m_ptr   = (w + 1) % N;
            end else begin
                m_valid = 1'b0;
            end
        end else begin
            chk("req_ready_stall", 64'(req_ready), 64'd0);
        end
    endtask

    // Monitor: every accepted output must match the oldest expected item.
    initial begin
        item_t it;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", 64'd1, 64'd0);
                end else begin
                    it = exp_q.pop_front();
                    chk("out_data", 64'(out_data), 64'(it.d));
                    chk("out_src", 64'(out_src), 64'(it.s));
                end
            end
        end
    end

    initial begin
        int           exp3[4];
        logic [W-1:0] expd;
        exp3 = '{0, 1, 2, 0};
        expd = '0;

        cycle(1'b1, 4'b0000, 1'b0);
        cycle(1'b1, 4'b0000, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 4'b0000, 1'(i % 2));
            chk("idle_out_data", 64'(out_data), 64'd0);
            chk("idle_out_src", 64'(out_src), 64'd0);
        end

        for (int i = 0; i < 8; i++) cycle(1'b0, 4'b1111, 1'b1);

        cycle(1'b0, 4'b0110, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 4'b0110, 1'b0);
            chk("stall_src", 64'(out_src), 64'd1);
        end
        cycle(1'b0, 4'b0110, 1'b1);

        cycle(1'b0, 4'b0001, 1'b1);
        chk("wrap_grant", 64'(grant), 64'b0001);
        cycle(1'b0, 4'b1111, 1'b1);
        chk("ptr_after_wrap", 64'(grant), 64'b0010);

        cycle(1'b0, 4'b1000, 1'b0);
        cycle(1'b0, 4'b1000, 1'b0);
        cycle(1'b1, 4'b1000, 1'b0);
        cycle(1'b0, 4'b1111, 1'b1);
        chk("post_rst_valid", {63'd0, out_valid}, 64'd0);
        chk("post_rst_grant", 64'(grant), 64'b0001);

        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 49) == 0), 4'($urandom), 1'($urandom_range(0, 3) != 0));
        end

        for (int i = 0; i < 4; i++) cycle(1'b0, 4'b0000, 1'b1);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            if (k > 0) begin
                chk("n3_valid", {63'd0, ov3}, 64'd1);
                chk("n3_src", 64'(os3), 64'(exp3[k-1]));
                chk("n3_data", 64'(od3), 64'(expd));
            end
            if (k < 4) begin
                rv3 = 3'b111;
                for (int j = 0; j < 3; j++) rd3[j] = $urandom;
                expd = rd3[exp3[k]];
            end else begin
                rv3 = 3'b000;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
